// File: rtl/pattern_detect.sv
// pattern_detect: masked 48-bit pattern / complement-pattern detector for the slice result
// Define PATTERN_DETECT_PAST_EN to add registered previous-cycle match flags.
module pattern_detect #(
    parameter logic [47:0] pattern_input = 48'd2,
    parameter logic [47:0] mask_input    = 48'd0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [47:0] P,
    input  logic [47:0] C,
    input  logic        SEL_PATTERN,
    input  logic        SEL_MASK,
`ifdef PATTERN_DETECT_PAST_EN
    output logic        PATTERN_DETECT_PAST,
    output logic        PATTERNB_DETECT_PAST,
`endif
    output logic        PATTERN_DETECT,
    output logic        PATTERNB_DETECT
);
    logic [47:0] pat;
    logic [47:0] msk;
    logic [47:0] diff;
    always_comb begin
        pat  = SEL_PATTERN ? pattern_input : C;
        msk  = SEL_MASK ? mask_input : C;
        diff = P ^ pat;
        PATTERN_DETECT  = &(~diff | msk);
        PATTERNB_DETECT = &(diff | msk);
    end
`ifdef PATTERN_DETECT_PAST_EN
    always_ff @(posedge CLK) begin
        PATTERN_DETECT_PAST  <= RST ? 1'b0 : PATTERN_DETECT;
        PATTERNB_DETECT_PAST <= RST ? 1'b0 : PATTERNB_DETECT;
    end
`else
    // Clock and reset are kept as ports so both builds share one footprint.
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RST;
`endif
endmodule

// File: tb/tb_pattern_detect.sv
// tb_pattern_detect: randomized scoreboard bench for pattern_detect against a per-bit counting model
// History flags are checked only when PATTERN_DETECT_PAST_EN is defined.
module tb_pattern_detect;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] p = '0;
    logic [47:0] c = '0;
    logic        sel_pattern = 1'b1;
    logic        sel_mask = 1'b1;
    logic        pd;
    logic        pbd;
    logic        pdp = 1'b0;
    logic        pbdp = 1'b0;
`ifdef PATTERN_DETECT_PAST_EN
    logic        pdp_w;
    logic        pbdp_w;
    always_comb begin
        pdp  = pdp_w;
        pbdp = pbdp_w;
    end
`endif

    typedef struct packed {
        logic pd;
        logic pbd;
        logic pdp;
        logic pbdp;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   miscompares = 0;
    logic prev_rst = 1'b1;
    logic prev_pd = 1'b0;
    logic prev_pbd = 1'b0;

    always #5 clk = ~clk;

    pattern_detect dut (
        .CLK(clk),
        .RST(rst),
        .P(p),
        .C(c),
        .SEL_PATTERN(sel_pattern),
        .SEL_MASK(sel_mask),
`ifdef PATTERN_DETECT_PAST_EN
        .PATTERN_DETECT_PAST(pdp_w),
        .PATTERNB_DETECT_PAST(pbdp_w),
`endif
        .PATTERN_DETECT(pd),
        .PATTERNB_DETECT(pbd)
    );

    // Counts cared-about bits that agree / disagree with the selected pattern.
    function automatic logic [1:0] model(input logic [47:0] pv, input logic [47:0] cv,
                                         input logic sp, input logic sm);
        logic [47:0] pt;
        logic [47:0] mk;
        int care;
        int eq;
        int ne;
        pt = sp ? 48'd2 : cv;
        mk = sm ? 48'd0 : cv;
        care = 0;
        eq = 0;
        ne = 0;
        for (int i = 0; i < 48; i++) begin
            if (mk[i] == 1'b0) begin
                care++;
                if (pv[i] == pt[i]) eq++;
                else ne++;
            end
        end
        return {eq == care, ne == care};
    endfunction

    task automatic apply(input logic [47:0] pv, input logic [47:0] cv,
                         input logic sp, input logic sm, input logic r);
        logic [1:0] m;
        exp_t e;
        @(posedge clk);
        #1;
        p = pv;
        c = cv;
        sel_pattern = sp;
        sel_mask = sm;
        rst = r;
        m = model(pv, cv, sp, sm);
        e.pd   = m[1];
        e.pbd  = m[0];
        e.pdp  = prev_rst ? 1'b0 : prev_pd;
        e.pbdp = prev_rst ? 1'b0 : prev_pbd;
        q.push_back(e);
        prev_rst = r;
        prev_pd  = m[1];
        prev_pbd = m[0];
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            n_vec++;
            if ({pd, pbd} !== {e.pd, e.pbd}) begin
                miscompares++;
                $display("FAIL detect vec %0d: P=%h C=%h sp=%b sm=%b got pd/pbd=%b%b want %b%b",
                         n_vec, p, c, sel_pattern, sel_mask, pd, pbd, e.pd, e.pbd);
            end
`ifdef PATTERN_DETECT_PAST_EN
            if ({pdp, pbdp} !== {e.pdp, e.pbdp}) begin
                miscompares++;
                $display("FAIL past vec %0d: got pdp/pbdp=%b%b want %b%b",
                         n_vec, pdp, pbdp, e.pdp, e.pbdp);
            end
`endif
        end
    end

    initial begin
        logic [47:0] rc;
        logic [47:0] rp;
        logic [47:0] pt;
        logic        sp;
        logic        sm;
        apply(48'd2, 48'd0, 1'b1, 1'b1, 1'b1);
        apply(48'd2, 48'd0, 1'b1, 1'b1, 1'b1);
        apply(48'd2, 48'd0, 1'b1, 1'b1, 1'b0);
        apply(48'd2, 48'd0, 1'b1, 1'b1, 1'b0);
        apply(48'd2, 48'd0, 1'b1, 1'b1, 1'b1);
        apply(48'd2, 48'd0, 1'b1, 1'b1, 1'b0);
        apply(48'hFFFF_FFFF_FFFD, 48'd0, 1'b1, 1'b1, 1'b0);
        apply(48'd3, 48'd0, 1'b1, 1'b1, 1'b0);
        apply(48'h1234_5678_9ABC, 48'h1234_5678_9ABC, 1'b0, 1'b1, 1'b0);
        apply(48'h1234_5678_9ABD, 48'h1234_5678_9ABC, 1'b0, 1'b1, 1'b0);
        apply(48'h0000_0000_0002, 48'hFFFF_FFFF_FFF0, 1'b1, 1'b0, 1'b0);
        apply(48'hABCD_EF00_0002, 48'hFFFF_FFFF_FFF0, 1'b1, 1'b0, 1'b0);
        apply(48'h0000_0000_0003, 48'hFFFF_FFFF_FFF0, 1'b1, 1'b0, 1'b0);
        apply(48'h5A5A_0000_1234, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        apply(48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 300; k++) begin
            rc = 48'({$urandom(), $urandom()});
            rp = 48'({$urandom(), $urandom()});
            sp = 1'($urandom_range(0, 1));
            sm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rc = rc & 48'({$urandom(), $urandom()}) & 48'({$urandom(), $urandom()});
            pt = sp ? 48'd2 : rc;
            case ($urandom_range(0, 4))
                0: rp = pt;
                1: rp = ~pt;
                2: rp = pt ^ (48'd1 << $urandom_range(0, 47));
                3: rp = ~pt ^ (48'd1 << $urandom_range(0, 47));
                default: ;
            endcase
            apply(rp, rc, sp, sm, 1'($urandom_range(0, 15) == 0));
        end
        for (int w = 0; w < 10 && q.size() != 0; w++) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end
endmodule
